// File: rtl/seg7_capture_pkg.sv
// Shared definitions for the seven-segment display capture block:
// segment patterns (active-low GFEDCBA), decode codes, FSM states and anode helpers.
package seg7_capture_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [3:0] CODE_INVALID = 4'hE;
   localparam logic [3:0] CODE_BLANK   = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HELD   = 2'd2
   } state_t;

   // True when exactly one anode enable is driven low.
   function automatic logic one_anode_low(input logic [3:0] an);
      logic r;
      case (an)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
         default:                            r = 1'b0;
      endcase
      return r;
   endfunction

   // Digit position selected by a one-low anode pattern; meaningless otherwise.
   function automatic logic [1:0] anode_pos(input logic [3:0] an);
      logic [1:0] r;
      case (an)
         4'b1110: r = 2'd0;
         4'b1101: r = 2'd1;
         4'b1011: r = 2'd2;
         4'b0111: r = 2'd3;
         default: r = 2'd0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seg7_capture_to_bcd.sv
// Combinational seven-segment to BCD decoder; unknown patterns flag invalid
// and decode to CODE_INVALID, the blank pattern decodes to CODE_BLANK.
module seg7_to_bcd
   import seg7_capture_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] value,
   output logic       invalid
);

   // Pattern lookup; anything not in the table is a corrupted or partial glyph.
   always_comb begin
      value   = CODE_INVALID;
      invalid = 1'b1;
      case (seg)
         SEG_0:     begin value = 4'h0;       invalid = 1'b0; end
         SEG_1:     begin value = 4'h1;       invalid = 1'b0; end
         SEG_2:     begin value = 4'h2;       invalid = 1'b0; end
         SEG_3:     begin value = 4'h3;       invalid = 1'b0; end
         SEG_4:     begin value = 4'h4;       invalid = 1'b0; end
         SEG_5:     begin value = 4'h5;       invalid = 1'b0; end
         SEG_6:     begin value = 4'h6;       invalid = 1'b0; end
         SEG_7:     begin value = 4'h7;       invalid = 1'b0; end
         SEG_8:     begin value = 4'h8;       invalid = 1'b0; end
         SEG_9:     begin value = 4'h9;       invalid = 1'b0; end
         SEG_BLANK: begin value = CODE_BLANK; invalid = 1'b0; end
         default:   begin value = CODE_INVALID; invalid = 1'b1; end
      endcase
   end

endmodule

// File: rtl/seg7_capture.sv
// Captures the digits shown on a multiplexed 4-digit seven-segment display by
// watching its anode/segment lines and accepting a digit once it is stable.
module seg7_capture
   import seg7_capture_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  an,
   input  logic [6:0]  seg,
   output logic [15:0] digits,
   output logic [3:0]  valid,
   output logic        frame_done,
   output logic        err
);

   localparam logic [7:0] CNT_SAT = 8'(STABLE_CYCLES);
   // Capture fires on the edge where the counter reaches STABLE_CYCLES-1.
   localparam logic [7:0] CNT_CAP = 8'(STABLE_CYCLES - 2);

   logic [3:0]  an_sample_r;
   logic [6:0]  seg_sample_r;
   logic [3:0]  an_prev_r;
   logic [6:0]  seg_prev_r;
   logic [7:0]  cnt_r;
   state_t      state_r;
   state_t      state_next_s;
   logic        capture_s;
   logic        changed_s;
   logic        one_low_s;
   logic [1:0]  pos_s;
   logic [3:0]  cap_mask_s;
   logic [3:0]  code_s;
   logic        invalid_s;
   logic [15:0] digits_r;
   logic [3:0]  valid_r;
   logic [3:0]  seen_r;
   logic        frame_done_r;
   logic        err_r;

   assign changed_s  = ({an_sample_r, seg_sample_r} != {an_prev_r, seg_prev_r});
   assign one_low_s  = one_anode_low(an_sample_r);
   assign pos_s      = anode_pos(an_sample_r);
   assign cap_mask_s = capture_s ? (4'b0001 << pos_s) : 4'b0000;

   seg7_to_bcd u_decode (
      .seg     (seg_sample_r),
      .value   (code_s),
      .invalid (invalid_s)
   );

   // Input sample register and its one-cycle-delayed copy.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         an_sample_r  <= 4'hF;
         seg_sample_r <= 7'h7F;
         an_prev_r    <= 4'hF;
         seg_prev_r   <= 7'h7F;
      end else begin
         an_sample_r  <= an;
         seg_sample_r <= seg;
         an_prev_r    <= an_sample_r;
         seg_prev_r   <= seg_sample_r;
      end
   end

   // Stability counter: restarts on any sample change, saturates at STABLE_CYCLES.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r <= 8'd0;
      end else if (changed_s) begin
         cnt_r <= 8'd0;
      end else if (cnt_r < CNT_SAT) begin
         cnt_r <= cnt_r + 8'd1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state and capture decision.
   always_comb begin
      state_next_s = state_r;
      capture_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (one_low_s) begin
               state_next_s = ST_SETTLE;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (!one_low_s) begin
               state_next_s = ST_IDLE;
            end else if (changed_s) begin
               state_next_s = ST_SETTLE;
            end else if (cnt_r == CNT_CAP) begin
               capture_s    = 1'b1;
               state_next_s = ST_HELD;
            end else begin
               state_next_s = ST_SETTLE;
            end
         end
         ST_HELD: begin
            if (!changed_s) begin
               state_next_s = ST_HELD;
            end else if (one_low_s) begin
               state_next_s = ST_SETTLE;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Captured digit storage, per-position valid flags and sticky decode error.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         digits_r <= 16'hFFFF;
         valid_r  <= 4'b0000;
         err_r    <= 1'b0;
      end else if (capture_s) begin
         digits_r[{pos_s, 2'b00} +: 4] <= code_s;
         valid_r                       <= valid_r | cap_mask_s;
         err_r                         <= err_r | invalid_s;
      end
   end

   // Frame tracking: a full seen mask pulses frame_done and restarts the mask,
   // keeping any capture that lands on the restart edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seen_r       <= 4'b0000;
         frame_done_r <= 1'b0;
      end else if (seen_r == 4'b1111) begin
         seen_r       <= cap_mask_s;
         frame_done_r <= 1'b1;
      end else begin
         seen_r       <= seen_r | cap_mask_s;
         frame_done_r <= 1'b0;
      end
   end

   assign digits     = digits_r;
   assign valid      = valid_r;
   assign frame_done = frame_done_r;
   assign err        = err_r;

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: directed scenarios plus randomized
// scanning, compared every cycle against a run-length reference model.
module tb_seg7_capture;

   localparam int S = 4;
   localparam logic [6:0] PAT [0:9] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   logic        clk;
   logic        rst_n;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic [15:0] digits;
   logic [3:0]  valid;
   logic        frame_done;
   logic        err;

   int tests = 0;
   int fails = 0;
   int pulses = 0;

   // reference model state
   logic [10:0] run_val;
   int          run_len;
   logic [15:0] m_digits;
   logic [3:0]  m_valid;
   logic [3:0]  m_seen;
   logic        m_err;
   logic        m_fd;

   seg7_capture #(.STABLE_CYCLES(S)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .an         (an),
      .seg        (seg),
      .digits     (digits),
      .valid      (valid),
      .frame_done (frame_done),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] ref_decode(input logic [6:0] s);
      if (s == 7'h7F) return {1'b0, 4'hF};
      for (int i = 0; i < 10; i++)
         if (s == PAT[i]) return {1'b0, 4'(i)};
      return {1'b1, 4'hE};
   endfunction

   function automatic int low_pos(input logic [3:0] a);
      int zeros = 0;
      int p = -1;
      for (int i = 0; i < 4; i++)
         if (a[i] == 1'b0) begin zeros++; p = i; end
      return (zeros == 1) ? p : -1;
   endfunction

   task automatic model_reset();
      run_val  = 11'h7FF;
      run_len  = 1;
      m_digits = 16'hFFFF;
      m_valid  = 4'b0000;
      m_seen   = 4'b0000;
      m_err    = 1'b0;
      m_fd     = 1'b0;
   endtask

   task automatic check_all();
      chk("digits", {16'h0, digits}, {16'h0, m_digits});
      chk("valid", {28'h0, valid}, {28'h0, m_valid});
      chk("err", {31'h0, err}, {31'h0, m_err});
      chk("frame_done", {31'h0, frame_done}, {31'h0, m_fd});
   endtask

   // One clock with the given pins; a digit is captured once the same value has
   // been seen on exactly S consecutive edges.
   task automatic step(input logic [3:0] a, input logic [6:0] s);
      logic [3:0] new_bit;
      logic [4:0] d;
      int p;
      an  = a;
      seg = s;
      @(posedge clk);
      new_bit = 4'b0000;
      m_fd = (m_seen == 4'b1111);
      p = low_pos(run_val[10:7]);
      if (run_len == S && p >= 0) begin
         d = ref_decode(run_val[6:0]);
         m_digits[p*4 +: 4] = d[3:0];
         m_valid[p] = 1'b1;
         m_err = m_err | d[4];
         new_bit[p] = 1'b1;
      end
      m_seen = m_fd ? new_bit : (m_seen | new_bit);
      if ({a, s} == run_val) begin
         if (run_len < 1000) run_len++;
      end else begin
         run_val = {a, s};
         run_len = 1;
      end
      #1;
      if (frame_done) pulses++;
      check_all();
   endtask

   task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
      repeat (n) step(a, s);
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      an    = 4'hF;
      seg   = 7'h7F;
      repeat (n) @(posedge clk);
      model_reset();
      #1;
      check_all();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [3:0] ra;
      logic [6:0] rs;
      rst_n = 1'b0;
      an    = 4'hF;
      seg   = 7'h7F;
      model_reset();

      // reset state
      do_reset(3);
      chk("reset_digits", {16'h0, digits}, 32'h0000FFFF);
      chk("reset_valid", {28'h0, valid}, 32'h0);

      // held one cycle too short: no capture
      hold(4'b1110, PAT[2], S - 1);
      hold(4'b1111, 7'h7F, 6);
      chk("short_hold_valid0", {31'h0, valid[0]}, 32'h0);

      // two anodes low: never captured
      hold(4'b1100, 7'b0000000, 20);
      hold(4'b1111, 7'h7F, 3);
      chk("two_anode_valid", {28'h0, valid}, 32'h0);

      // full scan 1,2,3,4
      pulses = 0;
      hold(4'b1110, PAT[1], 8);
      hold(4'b1101, PAT[2], 8);
      hold(4'b1011, PAT[3], 8);
      hold(4'b0111, PAT[4], 8);
      hold(4'b1111, 7'h7F, 4);
      chk("scan_digits", {16'h0, digits}, 32'h00004321);
      chk("scan_valid", {28'h0, valid}, 32'h0000000F);
      chk("scan_pulses", pulses, 1);

      // glitching segments under a constant anode
      for (int i = 0; i < 10; i++) hold(4'b1101, (i % 2 == 0) ? PAT[7] : PAT[8], 2);
      hold(4'b1111, 7'h7F, 3);
      chk("glitch_digit1", {28'h0, digits[7:4]}, 32'h2);

      // invalid pattern at position 2, sticky err
      hold(4'b1011, 7'b0101010, 8);
      chk("invalid_digit2", {28'h0, digits[11:8]}, 32'hE);
      chk("err_set", {31'h0, err}, 32'h1);
      pulses = 0;
      hold(4'b1011, PAT[7], 8);
      hold(4'b1111, 7'h7F, 4);
      chk("err_sticky", {31'h0, err}, 32'h1);
      chk("recapture_digit2", {28'h0, digits[11:8]}, 32'h7);
      chk("recapture_no_pulse", pulses, 0);

      // reset after three positions discards the partial frame
      do_reset(2);
      hold(4'b1110, PAT[5], 8);
      hold(4'b1101, PAT[6], 8);
      hold(4'b1011, PAT[9], 8);
      do_reset(2);
      pulses = 0;
      hold(4'b1101, PAT[5], 8);
      hold(4'b1111, 7'h7F, 4);
      chk("post_reset_valid", {28'h0, valid}, 32'h2);
      chk("post_reset_pulses", pulses, 0);

      // randomized scanning against the model
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 5))
            0: ra = 4'b1110;
            1: ra = 4'b1101;
            2: ra = 4'b1011;
            3: ra = 4'b0111;
            4: ra = 4'b1111;
            default: ra = 4'($urandom);
         endcase
         if ($urandom_range(0, 9) < 7) rs = PAT[$urandom_range(0, 9)];
         else if ($urandom_range(0, 1) == 0) rs = 7'h7F;
         else rs = 7'($urandom);
         hold(ra, rs, $urandom_range(1, 8));
         if (n == 150) do_reset(1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 Parameter: STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured; legal range 2..255.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 an  input  4  anode enables, active-low, an[i]=0 selects digit position i.
REQ-005 seg  input  7  segment lines, active-low, bit order GFEDCBA (seg[0]=A).
REQ-006 digits  output  16  captured values; digits[4i+3:4i] holds position i.
REQ-007 valid  output  4  valid[i]=1 once position i has been captured since reset.
REQ-008 frame_done  output  1  one-cycle pulse when all four positions have been captured since the previous pulse.
REQ-009 err  output  1  sticky flag: an unrecognised segment pattern was captured.

Function
REQ-010 Inputs {an,seg} shall be registered once into a sample register; all decisions use the sample register and the previous sample.
REQ-011 Stability counter (8 bit) shall reset to 0 when the sample differs from the previous sample, else increment, saturating at STABLE_CYCLES.
REQ-012 FSM states: IDLE, SETTLE, HELD.
REQ-013 IDLE: no anode low or more than one anode low in sample; counter ignored; on sample with exactly one anode low -> SETTLE.
REQ-014 SETTLE: on sample change with exactly one anode low -> stay SETTLE (counter restarts); on zero/multiple anodes -> IDLE; when counter reaches STABLE_CYCLES-1 with unchanged sample -> capture, -> HELD.
REQ-015 HELD: no further captures; any sample change -> SETTLE (one anode low) or IDLE (otherwise).
REQ-016 Capture writes decoded nibble to the selected position, sets valid[i] and internal seen[i], all on the same edge as the HELD transition.
REQ-017 Decode (active-low GFEDCBA): 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9, 1111111 (blank)->4'hF.
REQ-018 Any other pattern shall decode to 4'hE, be written and marked valid, and set err.
REQ-019 When seen becomes 4'b1111, frame_done shall be 1 for exactly the next cycle and seen shall clear to 4'b0000 on that same edge.
REQ-020 A capture coinciding with the seen-clear edge shall be retained: seen becomes the new position's bit only.
REQ-021 Latency: pattern stable on pins at edge k is captured at edge k+STABLE_CYCLES; digits/valid reflect it after that edge.
REQ-022 Re-capture of an already-seen position before the frame completes updates digits but does not pulse frame_done.
REQ-023 An anode held constant while seg changes shall restart SETTLE (glitch rejection).

Reset
REQ-024 While rst_n=0 at a rising edge: digits=16'hFFFF, valid=0, frame_done=0, err=0, seen=0, counter=0, sample registers=all ones, FSM=IDLE.
REQ-025 Reset asserted mid-SETTLE or mid-frame shall discard partial progress; no frame_done after release until four fresh captures.

Structure
REQ-026 Shared package shall hold the ten digit segment constants, SEG_BLANK, the FSM state typedef, and the decode codes 4'hE/4'hF.
REQ-027 Decode shall be a separate combinational sub-module seg7_to_bcd (7-bit active-low in, 4-bit value and invalid flag out).

Verification
REQ-028 Reset held 3 cycles -> digits=FFFF, valid=0, err=0, frame_done=0.
REQ-029 Scan an=1110/1101/1011/0111 each held 8 cycles with patterns 1,2,3,4 -> digits=16'h4321, valid=1111, one frame_done pulse after position 3 capture.
REQ-030 an=1110, seg=0100100 held exactly STABLE_CYCLES-1 cycles then changed -> no capture, valid[0]=0.
REQ-031 an=1100 (two anodes) with seg=0000000 for 20 cycles -> no capture, FSM IDLE.
REQ-032 Position 2 shows 0101010 -> digits[11:8]=4'hE, err=1 and remains 1 until reset.
REQ-033 Assert rst_n=0 after three positions captured, then scan one position -> no frame_done, valid shows only that position.
